// File: rtl/stopwatch_lap.sv
// Stopwatch with BCD display, lap memory and start/stop/lap/clear buttons.
// Optional countdown mode is compiled in with STOPWATCH_COUNTDOWN_EN.
`timescale 1ns/1ps

module stopwatch_lap #(
  parameter int unsigned TICK_DIV = 100000,
  parameter int unsigned SEC_MAX  = 99,
  parameter int unsigned LAP_AW   = 2
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              ENABLE,
  input  logic              START_STOP,
  input  logic              LAP_CLR,
  input  logic              VIEW_LAP,
  input  logic [LAP_AW-1:0] VIEW_SEL,
`ifdef STOPWATCH_COUNTDOWN_EN
  input  logic              MODE_DOWN,
  input  logic [6:0]        PRESET_SEC,
`endif
  output logic [3:0]        SEC_10,
  output logic [3:0]        SEC_01,
  output logic [3:0]        MSEC_10,
  output logic [3:0]        MSEC_01,
  output logic              RUNNING,
  output logic              DONE,
  output logic [LAP_AW:0]   LAP_CNT,
  output logic              LAP_FULL
);

  localparam int unsigned PresW     = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned Depth     = 2 ** LAP_AW;
  localparam logic [PresW-1:0] PresTop  = PresW'(TICK_DIV - 1);
  localparam logic [LAP_AW:0]  LapDepth = (LAP_AW + 1)'(Depth);
  localparam logic [3:0]       SecMaxT  = 4'(SEC_MAX / 10);
  localparam logic [3:0]       SecMaxO  = 4'(SEC_MAX % 10);
  localparam logic [15:0]      TimeMax  = {SecMaxT, SecMaxO, 4'd9, 4'd9};

  typedef enum logic [1:0] {StIdle, StRun, StStop, StDone} state_e;

  // Time is kept as four BCD digits {s10, s01, c10, c01}.
  function automatic logic [15:0] bcd_inc(input logic [15:0] t);
    logic [15:0] r;
    logic        carry;
    r     = t;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [15:0] r;
    logic        borrow;
    r      = t;
    borrow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (borrow) begin
        if (r[i*4 +: 4] == 4'd0) begin
          r[i*4 +: 4] = 4'd9;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  logic        mode_down;
  logic [15:0] preset_time;

`ifdef STOPWATCH_COUNTDOWN_EN
  localparam logic [6:0] SecMax7 = 7'(SEC_MAX);
  logic [6:0] preset_clamp;
  assign mode_down    = MODE_DOWN;
  assign preset_clamp = (PRESET_SEC > SecMax7) ? SecMax7 : PRESET_SEC;
  assign preset_time  = {4'(preset_clamp / 7'd10), 4'(preset_clamp % 7'd10), 8'h00};
`else
  assign mode_down   = 1'b0;
  assign preset_time = '0;
`endif

  // Button synchronizers: [0],[1] synchronize, [2] holds history for edge detect.
  logic [2:0] ss_sync_q, lc_sync_q;
  logic       ss_pulse_q, lc_pulse_q;
  logic [1:0] rst_rdy_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rst_rdy_q  <= '0;
      ss_sync_q  <= '0;
      lc_sync_q  <= '0;
      ss_pulse_q <= 1'b0;
      lc_pulse_q <= 1'b0;
    end else begin
      rst_rdy_q  <= {rst_rdy_q[0], 1'b1};
      ss_sync_q  <= {ss_sync_q[1:0], START_STOP};
      lc_sync_q  <= {lc_sync_q[1:0], LAP_CLR};
      ss_pulse_q <= ss_sync_q[1] & ~ss_sync_q[2] & rst_rdy_q[1] & ENABLE;
      lc_pulse_q <= lc_sync_q[1] & ~lc_sync_q[2] & rst_rdy_q[1] & ENABLE;
    end
  end

  state_e            state_q;
  logic [PresW-1:0]  presc_q;
  logic [15:0]       time_q;
  logic [LAP_AW:0]   lap_cnt_q;
  logic              lap_full_q;
  logic              running_q;
  logic              done_q;
  logic              down_q;

  logic lap_req, lap_room, lap_we;

  // Start has priority: a lap/clear pulse in the same cycle is dropped.
  assign lap_req  = ENABLE && (state_q == StRun) && lc_pulse_q && !ss_pulse_q;
  assign lap_room = (lap_cnt_q != LapDepth);
  assign lap_we   = lap_req && lap_room;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= StIdle;
      presc_q    <= '0;
      time_q     <= '0;
      lap_cnt_q  <= '0;
      lap_full_q <= 1'b0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      down_q     <= 1'b0;
    end else if (!ENABLE) begin
      state_q    <= StIdle;
      presc_q    <= '0;
      time_q     <= '0;
      lap_cnt_q  <= '0;
      lap_full_q <= 1'b0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      down_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          time_q <= mode_down ? preset_time : '0;
          if (ss_pulse_q) begin
            state_q   <= StRun;
            running_q <= 1'b1;
            presc_q   <= '0;
            down_q    <= mode_down;
          end
        end
        StRun: begin
          if (ss_pulse_q) begin
            state_q   <= StStop;
            running_q <= 1'b0;
          end else begin
            if (lap_req) begin
              if (lap_room) lap_cnt_q  <= lap_cnt_q + 1'b1;
              else          lap_full_q <= 1'b1;
            end
            if (presc_q == PresTop) begin
              presc_q <= '0;
              if (down_q) begin
                if (time_q == 16'h0000 || bcd_dec(time_q) == 16'h0000) begin
                  time_q    <= '0;
                  state_q   <= StDone;
                  running_q <= 1'b0;
                  done_q    <= 1'b1;
                end else begin
                  time_q <= bcd_dec(time_q);
                end
              end else if (time_q == TimeMax) begin
                state_q   <= StDone;
                running_q <= 1'b0;
                done_q    <= 1'b1;
              end else begin
                time_q <= bcd_inc(time_q);
              end
            end else begin
              presc_q <= presc_q + 1'b1;
            end
          end
        end
        StStop: begin
          if (ss_pulse_q) begin
            state_q   <= StRun;
            running_q <= 1'b1;
          end else if (lc_pulse_q) begin
            state_q    <= StIdle;
            presc_q    <= '0;
            time_q     <= '0;
            lap_cnt_q  <= '0;
            lap_full_q <= 1'b0;
          end
        end
        StDone: begin
          // Start is ignored here, but still suppresses a coincident clear.
          if (lc_pulse_q && !ss_pulse_q) begin
            state_q    <= StIdle;
            presc_q    <= '0;
            time_q     <= '0;
            lap_cnt_q  <= '0;
            lap_full_q <= 1'b0;
            done_q     <= 1'b0;
          end
        end
        default: begin
          state_q   <= StIdle;
          running_q <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  // Lap contents are never cleared; LAP_CNT gates what is visible.
  logic [15:0] lap_mem [Depth];

  always_ff @(posedge CLK) begin
    if (lap_we) lap_mem[lap_cnt_q[LAP_AW-1:0]] <= time_q;
  end

  logic        view_hit;
  logic [15:0] disp_d, disp_q;

  always_comb begin
    view_hit = ({1'b0, VIEW_SEL} < lap_cnt_q);
    disp_d   = time_q;
    if (VIEW_LAP) disp_d = view_hit ? lap_mem[VIEW_SEL] : 16'h0000;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) disp_q <= '0;
    else          disp_q <= disp_d;
  end

  assign {SEC_10, SEC_01, MSEC_10, MSEC_01} = disp_q;
  assign RUNNING  = running_q;
  assign DONE     = done_q;
  assign LAP_CNT  = lap_cnt_q;
  assign LAP_FULL = lap_full_q;

endmodule

// File: tb/tb_stopwatch_lap.sv
// Directed scoreboard bench for stopwatch_lap (TICK_DIV=4, SEC_MAX=3, LAP_AW=1).
// Countdown checks are added when STOPWATCH_COUNTDOWN_EN is defined.
`timescale 1ns/1ps

module tb_stopwatch_lap;

  localparam int unsigned TickDiv = 4;
  localparam int unsigned SecMax  = 3;
  localparam int unsigned LapAw   = 1;
  localparam int          MaxTicks = SecMax * 100 + 99;

  logic             CLK = 1'b0;
  logic             RESET_N = 1'b0;
  logic             ENABLE = 1'b1;
  logic             START_STOP = 1'b0;
  logic             LAP_CLR = 1'b0;
  logic             VIEW_LAP = 1'b0;
  logic [LapAw-1:0] VIEW_SEL = '0;
`ifdef STOPWATCH_COUNTDOWN_EN
  logic             MODE_DOWN = 1'b0;
  logic [6:0]       PRESET_SEC = '0;
`endif
  logic [3:0]       SEC_10, SEC_01, MSEC_10, MSEC_01;
  logic             RUNNING, DONE, LAP_FULL;
  logic [LapAw:0]   LAP_CNT;

  stopwatch_lap #(
    .TICK_DIV (TickDiv),
    .SEC_MAX  (SecMax),
    .LAP_AW   (LapAw)
  ) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .ENABLE     (ENABLE),
    .START_STOP (START_STOP),
    .LAP_CLR    (LAP_CLR),
    .VIEW_LAP   (VIEW_LAP),
    .VIEW_SEL   (VIEW_SEL),
`ifdef STOPWATCH_COUNTDOWN_EN
    .MODE_DOWN  (MODE_DOWN),
    .PRESET_SEC (PRESET_SEC),
`endif
    .SEC_10     (SEC_10),
    .SEC_01     (SEC_01),
    .MSEC_10    (MSEC_10),
    .MSEC_01    (MSEC_01),
    .RUNNING    (RUNNING),
    .DONE       (DONE),
    .LAP_CNT    (LAP_CNT),
    .LAP_FULL   (LAP_FULL)
  );

  always #5 CLK = ~CLK;

  int          n_asserts = 0;
  int          n_fail    = 0;
  // Reference: adv counts clock edges on which the watch is counting.
  int          adv       = 0;
  bit          m_run     = 1'b0;
  bit          m_done    = 1'b0;
  int          nlap      = 0;
  logic [15:0] lap_exp [2];
  string       tag_q [$];
  logic [31:0] exp_q [$];

  function automatic logic [15:0] to_bcd(input int t);
    int s;
    int c;
    s = t / 100;
    c = t % 100;
    return {4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  function automatic int ticks(input int a);
    return (a / TickDiv > MaxTicks) ? MaxTicks : a / TickDiv;
  endfunction

  function automatic logic [15:0] disp();
    return {SEC_10, SEC_01, MSEC_10, MSEC_01};
  endfunction

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
      if (m_run) begin
        adv++;
        if (adv / TickDiv > MaxTicks) begin
          m_run  = 1'b0;
          m_done = 1'b1;
        end
      end
    end
  endtask

  task automatic expect_val(input string tag, input logic [31:0] e);
    tag_q.push_back(tag);
    exp_q.push_back(e);
  endtask

  task automatic check_val(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    n_asserts++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %0h required an expectation", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", t, obs, e);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] e);
    expect_val(tag, e);
    check_val(obs);
  endtask

  // Expected live time is queued now and appears on the registered digits next cycle.
  task automatic check_time(input string tag);
    expect_val(tag, 32'(to_bcd(ticks(adv))));
    cyc(1);
    check_val(32'(disp()));
  endtask

  task automatic check_view(input string tag, input logic [15:0] e);
    expect_val(tag, 32'(e));
    cyc(1);
    check_val(32'(disp()));
  endtask

  task automatic press(input bit st, input bit lc);
    START_STOP = st;
    LAP_CLR    = lc;
    cyc(3);
    if (st && !m_done) begin
      @(posedge CLK);
      #1;
      m_run = !m_run;
    end else if (lc && m_run) begin
      if (nlap < 2) lap_exp[nlap] = to_bcd(ticks(adv));
      nlap++;
      cyc(1);
    end else if (lc) begin
      @(posedge CLK);
      #1;
      adv    = 0;
      m_done = 1'b0;
      nlap   = 0;
    end else begin
      cyc(1);
    end
    START_STOP = 1'b0;
    LAP_CLR    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "timeout");
  end

  initial begin
    #2;
    chk("rst_digits", 32'(disp()), 32'h0);
    chk("rst_running", 32'(RUNNING), 32'h0);
    chk("rst_lap_cnt", 32'(LAP_CNT), 32'h0);
    cyc(3);
    RESET_N = 1'b1;
    cyc(3);

    // Start latency: input first sampled at the next edge, RUNNING three edges later.
    START_STOP = 1'b1;
    cyc(3);
    chk("start_lat_early", 32'(RUNNING), 32'h0);
    @(posedge CLK);
    #1;
    m_run = 1'b1;
    START_STOP = 1'b0;
    chk("start_lat_exact", 32'(RUNNING), 32'h1);

    // Lap on the 00.09 -> 00.10 tick edge stores 00.09.
    cyc(36 - adv);
    press(1'b0, 1'b1);
    chk("lap1_cnt", 32'(LAP_CNT), 32'h1);
    chk("lap1_val", 32'(lap_exp[0]), 32'h0009);
    cyc(58 - adv);
    check_time("live_0014");

    // Start and lap together: only stop happens; time and fraction then hold.
    press(1'b1, 1'b1);
    chk("both_stop_run", 32'(RUNNING), 32'h0);
    chk("both_stop_lapcnt", 32'(LAP_CNT), 32'h1);
    cyc(100);
    check_time("stop_hold");
    press(1'b1, 1'b1);
    chk("both_resume_run", 32'(RUNNING), 32'h1);
    chk("both_resume_lapcnt", 32'(LAP_CNT), 32'h1);
    for (int i = 0; i < 3; i++) check_time("resume_fraction");

    cyc(98 - adv);
    press(1'b0, 1'b1);
    chk("lap2_cnt", 32'(LAP_CNT), 32'h2);
    chk("lap2_full", 32'(LAP_FULL), 32'h0);
    cyc(158 - adv);
    press(1'b0, 1'b1);
    chk("lap3_cnt", 32'(LAP_CNT), 32'h2);
    chk("lap3_full", 32'(LAP_FULL), 32'h1);

    VIEW_LAP = 1'b1;
    VIEW_SEL = 1'b1;
    check_view("view_sel1", 16'h0025);
    VIEW_SEL = 1'b0;
    check_view("view_sel0", lap_exp[0]);
    VIEW_LAP = 1'b0;

    cyc(400 - adv);
    check_time("one_second");
    chk("one_second_run", 32'(RUNNING), 32'h1);

    // Saturation at SEC_MAX.99.
    cyc(1596 - adv);
    check_time("max_time");
    cyc(3);
    chk("done_flag", 32'(DONE), 32'h1);
    chk("done_running", 32'(RUNNING), 32'h0);
    cyc(20);
    check_time("done_hold");
    press(1'b1, 1'b0);
    chk("done_ignore_start", 32'(DONE), 32'h1);
    cyc(2);
    press(1'b0, 1'b1);
    chk("clear_done", 32'(DONE), 32'h0);
    chk("clear_lapcnt", 32'(LAP_CNT), 32'h0);
    chk("clear_full", 32'(LAP_FULL), 32'h0);
    check_time("clear_time");

    // ENABLE low clears and masks buttons.
    press(1'b1, 1'b0);
    cyc(50);
    ENABLE = 1'b0;
    m_run  = 1'b0;
    cyc(1);
    adv = 0;
    chk("enable_low_run", 32'(RUNNING), 32'h0);
    check_time("enable_low_time");
    START_STOP = 1'b1;
    cyc(5);
    START_STOP = 1'b0;
    cyc(3);
    ENABLE = 1'b1;
    cyc(4);
    chk("enable_low_button", 32'(RUNNING), 32'h0);

    // View beyond LAP_CNT shows zeros even while live time is non-zero.
    press(1'b1, 1'b0);
    cyc(100 - adv);
    press(1'b0, 1'b1);
    VIEW_LAP = 1'b1;
    VIEW_SEL = 1'b1;
    check_view("view_empty", 16'h0000);
    VIEW_SEL = 1'b0;
    check_view("view_lap_new", lap_exp[0]);
    VIEW_LAP = 1'b0;

    // Asynchronous reset at 00.57, checked without any clock edge.
    cyc(228 - adv);
    check_time("pre_reset_0057");
    #2;
    RESET_N = 1'b0;
    #1;
    chk("areset_digits", 32'(disp()), 32'h0);
    chk("areset_running", 32'(RUNNING), 32'h0);
    chk("areset_lapcnt", 32'(LAP_CNT), 32'h0);
    m_run = 1'b0;
    adv   = 0;
    nlap  = 0;
    START_STOP = 1'b1;
    cyc(2);
    RESET_N = 1'b1;
    cyc(2);
    chk("release_no_early_edge", 32'(RUNNING), 32'h0);
    START_STOP = 1'b0;
    cyc(10);

`ifdef STOPWATCH_COUNTDOWN_EN
    ENABLE = 1'b0;
    cyc(2);
    ENABLE = 1'b1;
    MODE_DOWN  = 1'b1;
    PRESET_SEC = 7'd99;
    cyc(3);
    chk("cd_clamp", 32'(disp()), 32'h0300);
    PRESET_SEC = 7'd2;
    cyc(3);
    chk("cd_preset", 32'(disp()), 32'h0200);
    START_STOP = 1'b1;
    cyc(4);
    START_STOP = 1'b0;
    cyc(799);
    chk("cd_not_done", 32'(DONE), 32'h0);
    cyc(1);
    chk("cd_done", 32'(DONE), 32'h1);
    cyc(1);
    chk("cd_zero", 32'(disp()), 32'h0000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_lap.md
STOPWATCH_LAP -- requirements
Module: stopwatch_lap

Interface
REQ-001 Parameter TICK_DIV, default 100000, is the number of CLK cycles per 1/100 s tick (minimum 2).
REQ-002 Parameter SEC_MAX, default 99, is the highest seconds value (1..99).
REQ-003 Parameter LAP_AW, default 2, is the lap-memory address width; depth is 2**LAP_AW.
REQ-004 CLK  in  1  single system clock; all state changes on its rising edge.
REQ-005 RESET_N  in  1  asynchronous, active-low reset.
REQ-006 ENABLE  in  1  stopwatch mode select; low forces IDLE and clears all state.
REQ-007 START_STOP  in  1  asynchronous level button: start/stop.
REQ-008 LAP_CLR  in  1  asynchronous level button: lap while running, clear while stopped or DONE.
REQ-009 VIEW_LAP  in  1  high selects a stored lap for display instead of live time.
REQ-010 VIEW_SEL  in  LAP_AW  lap index to display.
REQ-011 SEC_10, SEC_01, MSEC_10, MSEC_01  out  4 each  BCD display digits.
REQ-012 RUNNING  out  1  high in RUN state.
REQ-013 DONE  out  1  high in DONE state.
REQ-014 LAP_CNT  out  LAP_AW+1  number of stored laps.
REQ-015 LAP_FULL  out  1  sticky; set when a lap is dropped because memory is full.

Function
REQ-016 Each button SHALL pass through a 2-flop synchronizer followed by a rising-edge detector; each press yields one internal pulse, and the state change is visible exactly 3 CLK cycles after the input is first sampled high.
REQ-017 The FSM SHALL have states IDLE, RUN, STOP and DONE: IDLE-start->RUN; RUN-start->STOP; STOP-start->RUN; STOP-clear->IDLE; DONE-clear->IDLE; start is ignored in DONE.
REQ-018 The prescaler SHALL count 0..TICK_DIV-1 only in RUN, emit a one-cycle tick at the terminal count, clear on IDLE->RUN, and hold its value in STOP so that resume keeps the fraction.
REQ-019 On each tick in up mode, centiseconds SHALL increment 0..99, wrapping to 0 with a seconds carry.
REQ-020 At SEC_MAX.99, the next tick SHALL leave the time unchanged and enter DONE; time holds until clear.
REQ-021 A lap pulse in RUN SHALL write the pre-tick time to slot LAP_CNT and increment LAP_CNT; when LAP_CNT equals depth, the write is dropped and LAP_FULL is set.
REQ-022 A lap pulse while the time is a tick edge SHALL store the value held before the increment.
REQ-023 If start and lap/clear pulses occur in the same cycle, start SHALL win and the lap/clear is discarded.
REQ-024 Clear (STOP or DONE ->IDLE) SHALL zero time, prescaler, LAP_CNT and LAP_FULL; lap memory contents need not be cleared.
REQ-025 The digits SHALL be registered, with 1 cycle latency from time or view changes.
REQ-026 The digits SHALL show lap[VIEW_SEL] when VIEW_LAP=1 and VIEW_SEL<LAP_CNT, 00.00 when VIEW_LAP=1 and VIEW_SEL>=LAP_CNT, and live time otherwise.
REQ-027 ENABLE low SHALL apply the REQ-024 clear synchronously and hold IDLE; button edges are ignored while it is low.

Reset
REQ-028 RESET_N low SHALL immediately set IDLE, all digits 0, RUNNING=0, DONE=0, LAP_CNT=0, LAP_FULL=0, prescaler 0, and synchronizers 0, including mid-run.
REQ-029 Deassertion SHALL be synchronized internally; the first button edge is honoured no earlier than 2 cycles after release.

Configuration
REQ-030 With STOPWATCH_COUNTDOWN_EN defined, ports MODE_DOWN (in, 1) and PRESET_SEC (in, 7) SHALL exist.
REQ-031 In IDLE with MODE_DOWN=1 under that macro, time SHALL be loaded from min(PRESET_SEC,SEC_MAX).00 every cycle.
REQ-032 In countdown mode under that macro, MODE_DOWN SHALL be latched on IDLE->RUN, the count SHALL decrement with borrow, and reaching 00.00 SHALL enter DONE; a preset of 0 enters DONE on the first tick.
REQ-033 Without STOPWATCH_COUNTDOWN_EN, those ports SHALL be absent and the block SHALL count up only.

Verification (TICK_DIV=4)
REQ-034 Start, then wait 400 cycles -> 01.00 displayed and RUNNING=1; stop, wait 100 cycles, start -> the count resumes with no lost fraction.
REQ-035 SEC_MAX=3, run to 03.99 plus one tick -> DONE=1, RUNNING=0, display holds; then clear -> 00.00, IDLE.
REQ-036 LAP_AW=1, laps at 00.10, 00.25, 00.40 -> LAP_CNT=2, LAP_FULL=1; VIEW_LAP=1 with VIEW_SEL=1 -> 00.25.
REQ-037 Lap coincident with the 00.09->00.10 tick -> 00.09 stored; start and lap in the same cycle -> only RUNNING toggles, LAP_CNT unchanged.
REQ-038 RESET_N low at 00.57 while running -> all outputs 0 in the same cycle, with no clock edge needed.
REQ-039 With STOPWATCH_COUNTDOWN_EN, PRESET_SEC=2 and MODE_DOWN=1 -> 02.00 in IDLE; start, then 800 cycles -> 00.00 with DONE=1.
